// File: rtl/fifo_pkg.sv
// ============================================================================
// Package : fifo_pkg
// Shared state encoding, default parameters and buffer helpers for the reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   localparam int C_DEF_DATA_WIDTH = 8;
   localparam int C_DEF_DEPTH      = 16;
   localparam int C_DEF_BURST_LEN  = 4;
   localparam int C_DEF_TIMEOUT    = 32;
   localparam int C_OBUF_ENTRIES   = 3;

   function automatic logic [1:0] obuf_ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'(C_OBUF_ENTRIES - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream_obuf.sv
// ============================================================================
// Module : stream_obuf
// Three-entry circular output buffer presenting its head as a valid/ready beat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_obuf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = C_DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            occ_o
);

   logic [DATA_WIDTH-1:0] mem_q [C_OBUF_ENTRIES];
   logic [1:0]            wr_ptr_q;
   logic [1:0]            rd_ptr_q;
   logic [1:0]            occ_q;
   logic [1:0]            occ_d;
   logic                  w_push;
   logic                  w_pop;

   assign valid_o = (occ_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign occ_o   = occ_q;
   assign w_pop   = valid_o && ready_i;
   // A push while full is dropped unless a pop frees the slot in the same cycle.
   assign w_push  = push_i && ((occ_q != 2'(C_OBUF_ENTRIES)) || w_pop);

   always_comb begin
      occ_d = occ_q;
      case ({w_push, w_pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         occ_q    <= 2'd0;
         for (int i = 0; i < C_OBUF_ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= obuf_ptr_inc(wr_ptr_q);
         end
         if (w_pop) begin
            rd_ptr_q <= obuf_ptr_inc(rd_ptr_q);
         end
         occ_q <= occ_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module : fifo_burst_reader
// Drains an external FIFO in bursts of BURST_LEN beats, flushing a partial
// burst once data has waited TIMEOUT cycles. Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
   parameter int DEPTH      = C_DEF_DEPTH,
   parameter int BURST_LEN  = C_DEF_BURST_LEN,
   parameter int TIMEOUT    = C_DEF_TIMEOUT,
   parameter int ADDR_BITS  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [ADDR_BITS:0]    fifo_count,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy
);

   localparam int            CW        = ADDR_BITS + 1;
   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] C_BURST   = CW'(BURST_LEN);
   localparam logic [TW-1:0] C_TMO_MAX = TW'(TIMEOUT - 1);

   state_e                state_q;
   logic [CW-1:0]         fetch_left_q;
   logic [CW-1:0]         beats_left_q;
   logic [TW-1:0]         tmo_q;
   logic                  inflight_q;

   logic [1:0]            w_occ;
   logic                  w_buf_valid;
   logic [DATA_WIDTH-1:0] w_buf_data;
   logic                  w_rd_en;
   logic                  w_accept;

   // Reads are throttled so buffered plus in-flight words never exceed the
   // three buffer slots; nothing here depends on m_ready.
   assign w_rd_en = rst_n && (state_q == ST_BURST) && (fetch_left_q != '0) &&
                    !fifo_empty && (({1'b0, w_occ} + {2'b00, inflight_q}) < 3'd3);

   assign fifo_rd_en = w_rd_en;
   assign m_valid    = rst_n && w_buf_valid;
   assign m_data     = rst_n ? w_buf_data : '0;
   assign m_last     = m_valid && (beats_left_q == CW'(1));
   assign busy       = rst_n && (state_q != ST_IDLE);
   assign w_accept   = m_valid && m_ready;

   stream_obuf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_obuf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (fifo_rd_data),
      .ready_i     (m_ready),
      .valid_o     (w_buf_valid),
      .data_o      (w_buf_data),
      .occ_o       (w_occ)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         fetch_left_q <= '0;
         beats_left_q <= '0;
         tmo_q        <= '0;
         inflight_q   <= 1'b0;
      end else begin
         inflight_q <= w_rd_en;
         if (w_rd_en) begin
            fetch_left_q <= fetch_left_q - CW'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (fifo_count >= C_BURST) begin
                  fetch_left_q <= C_BURST;
                  beats_left_q <= C_BURST;
                  tmo_q        <= '0;
                  state_q      <= ST_BURST;
               end else if (fifo_empty || (fifo_count == '0)) begin
                  tmo_q <= '0;
               end else if (tmo_q >= C_TMO_MAX) begin
                  fetch_left_q <= fifo_count;
                  beats_left_q <= fifo_count;
                  tmo_q        <= '0;
                  state_q      <= ST_BURST;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ST_BURST: begin
               tmo_q <= '0;
               if (w_accept) begin
                  if (beats_left_q <= CW'(1)) begin
                     beats_left_q <= '0;
                     state_q      <= ST_IDLE;
                  end else begin
                     beats_left_q <= beats_left_q - CW'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module : tb_fifo_burst_reader
// Directed bench driving fifo_burst_reader from a behavioural FIFO model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int BL    = 4;
   localparam int TMO   = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;

   logic          wr_en;
   logic [DW-1:0] wr_data;
   bit            toggle_rdy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .BURST_LEN  (BL),
      .TIMEOUT    (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_count   (fifo_count),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy)
   );

   // Behavioural FIFO: read data appears the cycle after fifo_rd_en.
   logic [DW-1:0] fmem [DEPTH];
   int fwp, frp, fcnt;
   assign fifo_empty = (fcnt == 0);
   assign fifo_count = CW'(fcnt);

   always @(posedge clk) begin
      if (!rst_n) begin
         fwp <= 0; frp <= 0; fcnt <= 0; fifo_rd_data <= '0;
      end else begin
         if (fifo_rd_en && fcnt != 0) begin
            fifo_rd_data <= fmem[frp];
            frp <= (frp + 1) % DEPTH;
         end
         if (wr_en) begin
            fmem[fwp] <= wr_data;
            fwp <= (fwp + 1) % DEPTH;
         end
         fcnt <= fcnt + (wr_en ? 1 : 0) - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
      end
   end

   always @(posedge clk) begin
      #1;
      if (toggle_rdy) m_ready = ~m_ready;
   end

   // Beat monitor, sampled mid-cycle.
   int            cyc = 0;
   int            rd_cnt, viol_rd, viol_stab, first_ne, first_rd;
   logic [DW-1:0] bdata [$];
   logic          blast [$];
   int            bcyc  [$];
   logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [DW-1:0] pd = '0;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (fifo_rd_en) rd_cnt++;
         if (fifo_rd_en && fifo_empty) viol_rd++;
         if (first_ne < 0 && !fifo_empty) first_ne = cyc;
         if (first_rd < 0 && fifo_rd_en) first_rd = cyc;
         if (pv && !pr && !(m_valid && m_data == pd && m_last == pl)) viol_stab++;
         if (m_valid && m_ready) begin
            bdata.push_back(m_data);
            blast.push_back(m_last);
            bcyc.push_back(cyc);
         end
      end
      pv = m_valid && rst_n;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
   end

   task automatic clear_mon();
      bdata.delete(); blast.delete(); bcyc.delete();
      rd_cnt = 0; viol_rd = 0; viol_stab = 0; first_ne = -1; first_rd = -1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_en = 1'b0; toggle_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_mon();
   endtask

   task automatic write_words(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 wr_en = 1'b1; wr_data = base + DW'(i);
      end
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic wait_beats(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk);
         #2;
         if (bdata.size() >= n) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; m_ready = 1'b1; toggle_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      vectors++;
      if ({fifo_rd_en, m_valid, m_last, busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: rd_en/valid/last/busy got %b want 0000",
                  {fifo_rd_en, m_valid, m_last, busy});
      end
      vectors++;
      if (m_data !== '0) begin
         miscompares++;
         $display("FAIL reset_data: m_data got %h want 00", m_data);
      end
      #1 rst_n = 1'b1;
      clear_mon();
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({fifo_rd_en, m_valid, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL post_reset_idle: rd_en/valid/busy got %b want 000",
                  {fifo_rd_en, m_valid, busy});
      end
   endtask

   task automatic test_single_burst();
      bit ok;
      do_reset();
      m_ready = 1'b1;
      write_words(8'h11, 4);
      wait_beats(4, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL t1_timeout: beats got %0d want 4", bdata.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bdata[i] !== 8'h11 + DW'(i) || blast[i] !== (i == 3) ||
                bcyc[i] !== bcyc[0] + i) begin
               miscompares++;
               $display("FAIL t1_beat%0d: data %h last %b cyc+%0d want %h last %b cyc+%0d",
                        i, bdata[i], blast[i], bcyc[i] - bcyc[0], 8'h11 + DW'(i), (i == 3), i);
            end
         end
         vectors++;
         if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_busy_drop: busy got %b want 0", busy);
         end
      end
      repeat (5) @(posedge clk);
      #2;
      vectors++;
      if (bdata.size() !== 4 || rd_cnt !== 4) begin
         miscompares++;
         $display("FAIL t1_totals: beats %0d reads %0d want 4 4", bdata.size(), rd_cnt);
      end
   endtask

   task automatic test_partial_timeout();
      bit ok;
      int lo;
      do_reset();
      m_ready = 1'b1;
      write_words(8'hA0, 2);
      wait_beats(2, ok);
      lo = first_rd - first_ne;
      // Data waits TIMEOUT-1 counted cycles plus the decision cycle before reading.
      vectors++;
      if (!ok || first_ne < 0 || first_rd < 0 || lo < TMO - 1 || lo > TMO) begin
         miscompares++;
         $display("FAIL t2_wait: idle cycles got %0d want %0d..%0d (ok=%0d)",
                  lo, TMO - 1, TMO, ok);
      end
      if (ok) begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bdata[i] !== 8'hA0 + DW'(i) || blast[i] !== (i == 1)) begin
               miscompares++;
               $display("FAIL t2_beat%0d: data %h last %b want %h last %b",
                        i, bdata[i], blast[i], 8'hA0 + DW'(i), (i == 1));
            end
         end
      end
      repeat (4) @(posedge clk);
      #2;
      vectors++;
      if (bdata.size() !== 2 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL t2_end: beats %0d busy %b want 2 0", bdata.size(), busy);
      end
   endtask

   task automatic test_ready_toggle();
      bit ok;
      do_reset();
      m_ready = 1'b1;
      toggle_rdy = 1'b1;
      write_words(8'h30, 8);
      wait_beats(8, ok);
      toggle_rdy = 1'b0;
      #1 m_ready = 1'b1;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL t3_timeout: beats got %0d want 8", bdata.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bdata[i] !== 8'h30 + DW'(i) || blast[i] !== (i % 4 == 3)) begin
               miscompares++;
               $display("FAIL t3_beat%0d: data %h last %b want %h last %b",
                        i, bdata[i], blast[i], 8'h30 + DW'(i), (i % 4 == 3));
            end
         end
      end
      vectors++;
      if (viol_rd !== 0 || viol_stab !== 0) begin
         miscompares++;
         $display("FAIL t3_protocol: rd_on_empty %0d unstable_stalls %0d want 0 0",
                  viol_rd, viol_stab);
      end
   endtask

   task automatic test_stall();
      bit ok;
      do_reset();
      m_ready = 1'b0;
      write_words(8'h40, 4);
      repeat (12) @(posedge clk);
      #2;
      vectors++;
      if (rd_cnt > 3 || rd_cnt < 1 || m_valid !== 1'b1 || bdata.size() !== 0) begin
         miscompares++;
         $display("FAIL t4_stall: reads %0d valid %b beats %0d want 1..3 1 0",
                  rd_cnt, m_valid, bdata.size());
      end
      m_ready = 1'b1;
      wait_beats(4, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL t4_timeout: beats got %0d want 4", bdata.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bdata[i] !== 8'h40 + DW'(i) || blast[i] !== (i == 3)) begin
               miscompares++;
               $display("FAIL t4_beat%0d: data %h last %b want %h last %b",
                        i, bdata[i], blast[i], 8'h40 + DW'(i), (i == 3));
            end
         end
      end
      vectors++;
      if (viol_stab !== 0) begin
         miscompares++;
         $display("FAIL t4_stable: unstable_stalls %0d want 0", viol_stab);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      do_reset();
      m_ready = 1'b1;
      write_words(8'h50, 4);
      wait_beats(2, ok);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      vectors++;
      if (!ok || m_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_after_reset: valid %b busy %b want 0 0 (ok=%0d)",
                  m_valid, busy, ok);
      end
      repeat (6) @(posedge clk);
      #2;
      vectors++;
      if (bdata.size() !== 2 || bdata[0] !== 8'h50 || bdata[1] !== 8'h51) begin
         miscompares++;
         $display("FAIL t5_no_stale: beats %0d first %h %h want 2 50 51",
                  bdata.size(), bdata[0], bdata[1]);
      end
      clear_mon();
      write_words(8'h58, 4);
      wait_beats(4, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL t5_timeout: beats got %0d want 4", bdata.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bdata[i] !== 8'h58 + DW'(i) || blast[i] !== (i == 3)) begin
               miscompares++;
               $display("FAIL t5_beat%0d: data %h last %b want %h last %b",
                        i, bdata[i], blast[i], 8'h58 + DW'(i), (i == 3));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      m_ready = 1'b1;
      write_words(8'h60, 16);
      wait_beats(16, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL t6_timeout: beats got %0d want 16", bdata.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            vectors++;
            if (bdata[i] !== 8'h60 + DW'(i) || blast[i] !== (i % 4 == 3) ||
                (i % 4 != 0 && bcyc[i] !== bcyc[i-1] + 1)) begin
               miscompares++;
               $display("FAIL t6_beat%0d: data %h last %b gap %0d want %h last %b gap 1",
                        i, bdata[i], blast[i], (i > 0) ? bcyc[i] - bcyc[i-1] : 0,
                        8'h60 + DW'(i), (i % 4 == 3));
            end
         end
      end
      repeat (4) @(posedge clk);
      #2;
      vectors++;
      if (bdata.size() !== 16 || busy !== 1'b0 || viol_rd !== 0) begin
         miscompares++;
         $display("FAIL t6_end: beats %0d busy %b rd_on_empty %0d want 16 0 0",
                  bdata.size(), busy, viol_rd);
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; m_ready = 1'b1; toggle_rdy = 1'b0;
      clear_mon();
      test_reset();
      test_single_burst();
      test_partial_timeout();
      test_ready_toggle();
      test_stall();
      test_reset_mid_burst();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
